// File: rtl/pin_input_sampler.sv
// pin_input_sampler: two-flop synchronizer, per-bit debouncer and
// hold-able publish register for the MCU-FPGA bus input pins.
module pin_input_sampler #(
  parameter int NPORTS         = 17,
  parameter int SAMPLE_DIV     = 50,
  parameter int STABLE_SAMPLES = 4
) (
  input  logic              CLK50,
  input  logic              RST,
  input  logic [7:0]        raw_pins [0:NPORTS-1],
  input  logic              hold,
  input  logic [NPORTS-1:0] change_clr,
  output logic [7:0]        input_pins_state [0:NPORTS-1],
  output logic [NPORTS-1:0] change_flags
);

  localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int CW = $clog2(STABLE_SAMPLES + 1);
  localparam logic [PW-1:0] PMAX = PW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_SAMPLES - 1);

  logic [PW-1:0]     pre;
  logic              tick;
  logic [7:0]        s1      [NPORTS];
  logic [7:0]        s2      [NPORTS];
  logic [7:0]        deb     [NPORTS];
  logic [7:0]        deb_nxt [NPORTS];
  logic [CW-1:0]     cnt     [NPORTS][8];
  logic [CW-1:0]     cnt_nxt [NPORTS][8];
  logic [NPORTS-1:0] flip;

  assign tick = (pre == PMAX);

  always_ff @(posedge CLK50) begin
    if (RST) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + PW'(1);
    end
  end

  // A differing sample only counts on tick cycles; any equal one restarts.
  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      deb_nxt[p] = deb[p];
      for (int b = 0; b < 8; b++) begin
        cnt_nxt[p][b] = cnt[p][b];
        if (tick) begin
          if (s2[p][b] == deb[p][b]) begin
            cnt_nxt[p][b] = '0;
          end else if (cnt[p][b] == CMAX) begin
            deb_nxt[p][b] = s2[p][b];
            cnt_nxt[p][b] = '0;
          end else begin
            cnt_nxt[p][b] = cnt[p][b] + CW'(1);
          end
        end
      end
      flip[p] = |(deb_nxt[p] ^ deb[p]);
    end
  end

  always_ff @(posedge CLK50) begin
    if (RST) begin
      for (int p = 0; p < NPORTS; p++) begin
        s1[p]               <= '0;
        s2[p]               <= '0;
        deb[p]              <= '0;
        input_pins_state[p] <= '0;
        for (int b = 0; b < 8; b++) begin
          cnt[p][b] <= '0;
        end
      end
      change_flags <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        s1[p]  <= raw_pins[p];
        s2[p]  <= s1[p];
        deb[p] <= deb_nxt[p];
        if (!hold) begin
          input_pins_state[p] <= deb[p];
        end
        for (int b = 0; b < 8; b++) begin
          cnt[p][b] <= cnt_nxt[p][b];
        end
      end
      // set wins over a simultaneous clear
      change_flags <= flip | (change_flags & ~change_clr);
    end
  end

endmodule

// File: doc/pin_input_sampler.md
# pin_input_sampler

Upstream stage of the MCU–FPGA bus. Takes the raw FPGA input pins (17 ports × 8 bits) and passes them through a two-flop synchronizer and a per-bit debouncer. It publishes the result as the `input_pins_state[0:16]` array that the bus slave returns to the MCU on reads. While `hold` is high, the published array is frozen so a bus read sees a coherent snapshot. A sticky per-port change flag lets firmware poll for activity.

## Interface
- `NPORTS`, default 17: number of 8-bit pin ports.
- `SAMPLE_DIV`, default 50: CLK50 cycles per debounce sample tick (1 µs at 50 MHz); legal range ≥1.
- `STABLE_SAMPLES`, default 4: consecutive differing samples required to accept a new level; legal range ≥1.

- `CLK50`  in  1: system clock; the only clock.
- `RST`  in  1: reset, synchronous, active-high.
- `raw_pins[0:NPORTS-1]`  in  8 each: asynchronous pin levels.
- `hold`  in  1: freezes the published state; connected to `mcu_mstr`.
- `change_clr`  in  NPORTS: per-port flag clear, one-cycle pulse.
- `input_pins_state[0:NPORTS-1]`  out  8 each: published debounced levels.
- `change_flags`  out  NPORTS: sticky "port changed" flags.

## Operation
- **Reset.** While `RST` is high at a CLK50 edge, everything clears to 0: sync flops, debounced bits, per-bit counters, prescaler, `input_pins_state`, `change_flags`. `RST` applied mid-debounce discards partial counts.
- **Synchronizer.** Each raw bit goes through s1 then s2, one flop each. Only s2 is used downstream.
- **Prescaler.**
  - Counts 0..SAMPLE_DIV-1 and wraps to 0.
  - `tick` is high in the cycle where the count equals SAMPLE_DIV-1.
  - SAMPLE_DIV=1 gives a tick every cycle.
  - The first tick after reset is in cycle SAMPLE_DIV.
- **Per-bit debounce**, with debounced bit d and counter c (width clog2(STABLE_SAMPLES+1)). Acts only on tick cycles:
  - s2 == d: c ← 0.
  - s2 != d and c == STABLE_SAMPLES-1: d ← s2, c ← 0.
  - s2 != d otherwise: c ← c+1.
  - Net effect: d flips on the STABLE_SAMPLES-th consecutive tick on which s2 differs from d.
  - Any equal sample restarts the count.
  - Non-tick cycles leave d and c unchanged.
- **Publish.**
  - Each cycle with `hold`=0: `input_pins_state` ← current d array.
  - `hold`=1: the register keeps its value.
  - Debouncing and flag setting continue during hold.
- **Change flags.**
  - `change_flags[p]` is set in the cycle after any d bit of port p flips, i.e. registered together with the new d.
  - `change_clr[p]` clears it.
  - Set and clear in the same cycle: set wins (flag = 1).
  - Hold does not affect flags.

## Timing
- Latency from a raw level change, held steady, to `input_pins_state`:
  - 2 cycles of synchronizer,
  - then STABLE_SAMPLES ticks (first tick 1..SAMPLE_DIV cycles after s2 changes),
  - then 1 publish cycle.
- Range: 3 + (STABLE_SAMPLES-1)·SAMPLE_DIV + 1 to 2 + STABLE_SAMPLES·SAMPLE_DIV + 1 cycles.
- With SAMPLE_DIV=1 and STABLE_SAMPLES=1 the latency is exactly 4 cycles.
- `change_flags[p]` rises 1 cycle before `input_pins_state[p]` updates when `hold`=0.
- `hold` falling edge: `input_pins_state` updates at the next CLK50 edge.
- `hold` rising: the value registered at the current edge is the last update.
- Rejected pulses: a pulse shorter than (STABLE_SAMPLES-1)·SAMPLE_DIV cycles never changes d.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Reset.** Drive `raw_pins` all 8'hFF, assert `RST` for 3 cycles, then release. Required:
  - `input_pins_state` all 8'h00 and `change_flags`=0 during reset and the cycle after.
  - Every port reads 8'hFF within 2+4·50+1 cycles.
- **Clean edge**, SAMPLE_DIV=4, STABLE_SAMPLES=3. Set `raw_pins[5]`: 8'h00→8'h04 and hold it. Required:
  - `input_pins_state[5]`=8'h04 between 12 and 15 cycles after the change.
  - `change_flags[5]` rises exactly 1 cycle earlier.
  - Other ports stay unchanged.
- **Glitch rejection**, SAMPLE_DIV=4, STABLE_SAMPLES=3. Pulse `raw_pins[0][7]` high for 6 cycles. Required: `input_pins_state[0]` stays 8'h00 and `change_flags[0]` stays 0 for 100 cycles.
- **Hold snapshot.** Raise `hold`, then change `raw_pins[16]` to 8'hA5. Required:
  - `input_pins_state[16]` stays at the old value while `hold`=1.
  - `change_flags[16]` sets.
  - 8'hA5 appears 1 cycle after `hold` falls.
- **Flag collision.** Pulse `change_clr[3]` in the same cycle the port-3 flag is set. Required:
  - Flag = 1.
  - A second `change_clr[3]` pulse one cycle later clears it to 0.
- **Minimum latency**, SAMPLE_DIV=1, STABLE_SAMPLES=1. Toggle `raw_pins[8]` 8'h00→8'h81. Required: `input_pins_state[8]`=8'h81 exactly 4 cycles later.
